hack_data_memory: RTL and testbench

HACK_DATA_MEMORY -- requirements
Module: hack_data_memory

---
 rtl/hack_mem_pkg.sv | 36 +++
 rtl/screen_fifo.sv | 74 +++++++
 rtl/hack_data_memory.sv | 96 +++++++++
 tb/tb_hack_data_memory.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared address map, display-entry type and address decoder for the Hack data memory.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE     = 15'h0000;
  localparam logic [14:0] SCREEN_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR     = 15'h6000;
  localparam int          RAM_WORDS    = 16384;
  localparam int          SCREEN_WORDS = 8192;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } disp_entry_t;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_SCREEN = 2'd1,
    REG_KBD    = 2'd2,
    REG_NONE   = 2'd3
  } region_e;

  function automatic region_e decode_region(input logic [14:0] addr);
    region_e r;
    if (addr < SCREEN_BASE) begin
      r = REG_RAM;
    end else if (addr < (SCREEN_BASE + 15'(SCREEN_WORDS))) begin
      r = REG_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REG_KBD;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/screen_fifo.sv
// Display-write FIFO: pointer-pair FIFO with an extra wrap bit and a sticky drop flag.
module screen_fifo
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  disp_entry_t push_entry_i,
  input  logic        ready_i,
  output logic        valid_o,
  output disp_entry_t head_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  disp_entry_t   mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          empty_s, full_s, pop_s, accept_s;

  assign empty_s  = (wr_q == rd_q);
  assign full_s   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_s    = !empty_s && ready_i;
  // A same-edge pop frees the slot, so a push into a full FIFO is still taken.
  assign accept_s = push_i && (!full_s || pop_s);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (accept_s) begin
      wr_d = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
    if (push_i && full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      mem_q[wr_q[AW-1:0]] <= push_entry_i;
    end
  end

  assign valid_o    = !empty_s;
  assign head_o     = empty_s ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen shadow and keyboard register, with screen writes
// mirrored into a display FIFO.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic [15:0] key_code,
  input  logic        key_press,
  input  logic        key_release,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [12:0] disp_addr,
  output logic [15:0] disp_data,
  output logic        disp_overflow
);

  logic [15:0] ram_q    [RAM_WORDS];
  logic [15:0] screen_q [SCREEN_WORDS];
  logic [15:0] kbd_q, kbd_d;
  region_e     region_s;
  logic [13:0] ram_idx_s;
  logic [12:0] scr_idx_s;
  logic        ram_we_s, scr_we_s;
  disp_entry_t push_entry_s, head_s;

  assign region_s  = decode_region(addressM);
  assign ram_idx_s = 14'(addressM - RAM_BASE);
  assign scr_idx_s = 13'(addressM - SCREEN_BASE);
  assign ram_we_s  = writeM && (region_s == REG_RAM);
  assign scr_we_s  = writeM && (region_s == REG_SCREEN);

  // Storage arrays are intentionally not reset so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= outM;
    end
    if (scr_we_s) begin
      screen_q[scr_idx_s] <= outM;
    end
  end

  always_comb begin
    kbd_d = kbd_q;
    if (key_press) begin
      kbd_d = key_code;
    end else if (key_release) begin
      kbd_d = 16'h0000;
    end else begin
      kbd_d = kbd_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kbd_q <= 16'h0000;
    end else begin
      kbd_q <= kbd_d;
    end
  end

  always_comb begin
    inM = 16'h0000;
    case (region_s)
      REG_RAM:    inM = ram_q[ram_idx_s];
      REG_SCREEN: inM = screen_q[scr_idx_s];
      REG_KBD:    inM = kbd_q;
      REG_NONE:   inM = 16'h0000;
      default:    inM = 16'h0000;
    endcase
  end

  assign push_entry_s.addr = scr_idx_s;
  assign push_entry_s.data = outM;

  screen_fifo #(.DEPTH(FIFO_DEPTH)) u_screen_fifo (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_i       (scr_we_s),
    .push_entry_i (push_entry_s),
    .ready_i      (disp_ready),
    .valid_o      (disp_valid),
    .head_o       (head_s),
    .overflow_o   (disp_overflow)
  );

  assign disp_addr = head_s.addr;
  assign disp_data = head_s.data;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory with a scoreboard of expected display entries.
module tb_hack_data_memory;
  import hack_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic [15:0] key_code;
  logic        key_press;
  logic        key_release;
  logic        disp_valid;
  logic        disp_ready;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        disp_overflow;

  int checks = 0;
  int errors = 0;
  disp_entry_t sb[$];

  always #5 clock = ~clock;

  hack_data_memory #(.FIFO_DEPTH(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .addressM      (addressM),
    .writeM        (writeM),
    .outM          (outM),
    .inM           (inM),
    .key_code      (key_code),
    .key_press     (key_press),
    .key_release   (key_release),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_addr     (disp_addr),
    .disp_data     (disp_data),
    .disp_overflow (disp_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; any transfer happening on that edge is scored first.
  task automatic tick();
    disp_entry_t e;
    #1;
    if (disp_valid === 1'b1 && disp_ready === 1'b1) begin
      check("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_addr", 32'(disp_addr), 32'(e.addr));
        check("pop_data", 32'(disp_data), 32'(e.data));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string tag);
    addressM = a;
    writeM   = 1'b0;
    #1;
    check(tag, 32'(inM), 32'(exp));
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d, input bit push);
    disp_entry_t e;
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    if (push) begin
      e.addr = 13'(a - 15'h4000);
      e.data = d;
      sb.push_back(e);
    end
    tick();
    writeM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    disp_entry_t e;
    reset = 1'b0; addressM = 15'h0000; writeM = 1'b0; outM = 16'h0000;
    key_code = 16'h0000; key_press = 1'b0; key_release = 1'b0; disp_ready = 1'b0;

    // Reset state
    @(posedge clock); #1;
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_addr", 32'(disp_addr), 32'd0);
    check("rst_data", 32'(disp_data), 32'd0);
    check("rst_ovf", 32'(disp_overflow), 32'd0);
    rd(15'h6000, 16'h0000, "rst_kbd");
    reset = 1'b1;
    tick();

    // RAM access and unmapped / keyboard writes
    wr(15'h0010, 16'h1234, 1'b0);
    rd(15'h0010, 16'h1234, "ram_0010");
    rd(15'h6005, 16'h0000, "unmapped_6005");
    wr(15'h3FFF, 16'h5A5A, 1'b0);
    rd(15'h3FFF, 16'h5A5A, "ram_3fff");
    rd(15'h0010, 16'h1234, "ram_0010_again");
    wr(15'h6005, 16'hDEAD, 1'b0);
    wr(15'h6000, 16'hBEEF, 1'b0);
    wr(15'h7FFF, 16'hCAFE, 1'b0);
    rd(15'h6005, 16'h0000, "unmapped_wr_6005");
    rd(15'h6000, 16'h0000, "kbd_wr_ignored");
    rd(15'h7FFF, 16'h0000, "unmapped_7fff");
    check("no_push_nonscreen", 32'(disp_valid), 32'd0);

    // Single screen write with sink ready; no same-cycle bypass
    disp_ready = 1'b1;
    addressM = 15'h4001; outM = 16'hFFFF; writeM = 1'b1;
    #1;
    check("no_bypass", 32'(disp_valid), 32'd0);
    e.addr = 13'h0001; e.data = 16'hFFFF;
    sb.push_back(e);
    tick();
    writeM = 1'b0;
    check("one_valid", 32'(disp_valid), 32'd1);
    check("one_addr", 32'(disp_addr), 32'h0001);
    check("one_data", 32'(disp_data), 32'hFFFF);
    rd(15'h4001, 16'hFFFF, "shadow_4001");
    tick();
    check("one_drained", 32'(disp_valid), 32'd0);

    // Five writes into a depth-4 FIFO with the sink stalled
    disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(15'h4000 + 15'(i), 16'hA000 + 16'(i), i < 4);
    end
    check("ovf_set", 32'(disp_overflow), 32'd1);
    check("full_valid", 32'(disp_valid), 32'd1);
    check("full_head_addr", 32'(disp_addr), 32'h0000);
    check("full_head_data", 32'(disp_data), 32'hA000);
    tick();
    tick();
    check("stall_addr", 32'(disp_addr), 32'h0000);
    check("stall_data", 32'(disp_data), 32'hA000);
    rd(15'h4004, 16'hA004, "shadow_dropped");
    disp_ready = 1'b1;
    repeat (4) tick();
    check("drain_empty", 32'(disp_valid), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);
    check("ovf_sticky", 32'(disp_overflow), 32'd1);

    // Clear overflow, then push+pop on the same edge while full
    disp_ready = 1'b0;
    reset = 1'b0; #1; reset = 1'b1;
    check("ovf_cleared", 32'(disp_overflow), 32'd0);
    wr(15'h5FFF, 16'hB000, 1'b1);
    wr(15'h4100, 16'hB001, 1'b1);
    wr(15'h4200, 16'hB002, 1'b1);
    wr(15'h4300, 16'hB003, 1'b1);
    disp_ready = 1'b1;
    wr(15'h4400, 16'hB004, 1'b1);
    disp_ready = 1'b0;
    check("pp_no_ovf", 32'(disp_overflow), 32'd0);
    check("pp_head_addr", 32'(disp_addr), 32'h0100);
    check("pp_head_data", 32'(disp_data), 32'hB001);
    disp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && disp_valid === 1'b1; k++) begin
      tick();
      n++;
    end
    check("pp_occupancy", 32'(n), 32'd4);
    check("pp_sb_empty", 32'(sb.size()), 32'd0);
    disp_ready = 1'b0;

    // Keyboard register
    key_code = 16'h0041; key_press = 1'b1;
    tick();
    key_press = 1'b0;
    rd(15'h6000, 16'h0041, "kbd_press");
    key_code = 16'h0042; key_press = 1'b1; key_release = 1'b1;
    tick();
    key_press = 1'b0; key_release = 1'b0;
    rd(15'h6000, 16'h0042, "kbd_press_wins");
    key_code = 16'h0099; key_release = 1'b1;
    tick();
    key_release = 1'b0;
    rd(15'h6000, 16'h0000, "kbd_release");
    key_code = 16'h0055; key_press = 1'b1;
    tick();
    key_press = 1'b0;

    // Reset with three entries pending
    for (int i = 0; i < 5; i++) begin
      wr(15'h4010 + 15'(i), 16'hC000 + 16'(i), i < 4);
    end
    check("pre_rst_ovf", 32'(disp_overflow), 32'd1);
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check("pre_rst_valid", 32'(disp_valid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(disp_valid), 32'd0);
    check("mid_rst_ovf", 32'(disp_overflow), 32'd0);
    check("mid_rst_addr", 32'(disp_addr), 32'd0);
    check("mid_rst_data", 32'(disp_data), 32'd0);
    rd(15'h6000, 16'h0000, "mid_rst_kbd");
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(disp_valid), 32'd0);
    rd(15'h0010, 16'h1234, "ram_kept");
    rd(15'h5FFF, 16'hB000, "shadow_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
